// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module twos_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // Pass through or negate.
  always_comb y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO.
// Signed ops run on magnitudes; signs are reapplied in the FIX state.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             state, state_d;
  op_e                op_in, op_q;
  logic               in_signed, in_div;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   ma, mb;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign busy      = (state != S_IDLE);

  twos_neg #(.WIDTH(WIDTH)) u_abs_a (
    .neg (in_signed & rs_val[WIDTH-1]), .a (rs_val), .y (abs_a));
  twos_neg #(.WIDTH(WIDTH)) u_abs_b (
    .neg (in_signed & rt_val[WIDTH-1]), .a (rt_val), .y (abs_b));
  twos_neg #(.WIDTH(2*WIDTH)) u_prod (
    .neg (sign_a ^ sign_b), .a (acc), .y (prod_s));
  twos_neg #(.WIDTH(WIDTH)) u_quot (
    .neg (sign_a ^ sign_b), .a (acc[WIDTH-1:0]), .y (quot_s));
  twos_neg #(.WIDTH(WIDTH)) u_rem (
    .neg (sign_a), .a (acc[2*WIDTH-1:WIDTH]), .y (rem_s));

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (op_is_div(op_q)) begin
      if (!div_diff[WIDTH])
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt == CW'(WIDTH-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and done pulse.
  // Divide-by-zero: restoring division leaves |rs| as remainder, so re-signing it
  // with sign_a recovers the original rs_val for HI; only LO needs overriding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op_in;
            sign_a <= in_signed & rs_val[WIDTH-1];
            sign_b <= in_signed & rt_val[WIDTH-1];
            ma     <= abs_a;
            mb     <= abs_b;
            acc    <= in_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            cnt    <= '0;
          end else begin
            if (mthi) hi <= wr_data;
            if (mtlo) lo <= wr_data;
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          if (op_is_div(op_q)) begin
            hi <= rem_s;
            lo <= (mb == '0) ? DIV0_LO : quot_s;
          end else begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
